// File: rtl/qupls_reglist_seq.sv
// Register bit-list sequencer: walks a 64-bit register bitmap four registers per
// enabled cycle and presents the register numbers to the extract stage.

package QuplsPkg;
    localparam int unsigned AREGNO_W = 7;
    typedef logic [AREGNO_W-1:0] aregno_t;
endpackage

module qupls_reglist_seq
    import QuplsPkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic          start_i,
    input  logic [63:0]   mask_i,
    output logic [6:0]    iRn0_o,
    output logic [6:0]    iRn1_o,
    output logic [6:0]    iRn2_o,
    output logic [6:0]    iRn3_o,
    output aregno_t       regcnt_o,
    output logic          busy_o,
    output logic          last_o
);

    localparam int unsigned MASK_W  = 64;
    localparam int unsigned SLOTS   = 4;
    localparam int unsigned RN_W    = 7;
    localparam logic [RN_W-1:0] NO_REG = 7'h7F;

    logic [MASK_W-1:0]           rem_q, rem_d;
    logic [SLOTS-1:0][RN_W-1:0]  irn_q, irn_d;
    aregno_t                     regcnt_q, regcnt_d;

    logic [MASK_W-1:0]           src_c;
    logic [MASK_W-1:0]           left_c;
    logic [SLOTS-1:0][RN_W-1:0]  grp_c;
    logic [2:0]                  nfound_c;

    // Pick the four lowest set bits of the active source mask; left_c is what remains.
    always_comb begin
        src_c    = (rem_q != '0) ? rem_q : mask_i;
        left_c   = src_c;
        grp_c    = {SLOTS{NO_REG}};
        nfound_c = 3'd0;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (left_c[i] && (nfound_c < 3'd4)) begin
                grp_c[nfound_c[1:0]] = {1'b0, 6'(i)};
                left_c[i]            = 1'b0;
                nfound_c             = nfound_c + 3'd1;
            end
        end
    end

    // Next-state selection: flush, stall, continue list, start list, or idle.
    always_comb begin
        rem_d    = rem_q;
        irn_d    = irn_q;
        regcnt_d = regcnt_q;
        if (flush_i) begin
            rem_d    = '0;
            irn_d    = {SLOTS{NO_REG}};
            regcnt_d = '0;
        end else if (en_i) begin
            if (rem_q != '0) begin
                // A pending remainder implies the previous group was full.
                rem_d    = left_c;
                irn_d    = grp_c;
                regcnt_d = AREGNO_W'(regcnt_q + AREGNO_W'(SLOTS));
            end else if (start_i) begin
                rem_d    = left_c;
                irn_d    = grp_c;
                regcnt_d = '0;
            end else begin
                irn_d    = {SLOTS{NO_REG}};
                regcnt_d = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q    <= '0;
            irn_q    <= {SLOTS{NO_REG}};
            regcnt_q <= '0;
        end else begin
            rem_q    <= rem_d;
            irn_q    <= irn_d;
            regcnt_q <= regcnt_d;
        end
    end

    assign iRn0_o   = irn_q[0];
    assign iRn1_o   = irn_q[1];
    assign iRn2_o   = irn_q[2];
    assign iRn3_o   = irn_q[3];
    assign regcnt_o = regcnt_q;
    assign busy_o   = (rem_q != '0);
    assign last_o   = (irn_q[0] != NO_REG) && (rem_q == '0);

endmodule

// File: tb/tb_qupls_reglist_seq.sv
// Directed bench for qupls_reglist_seq with hand-computed expected groups.

module tb_qupls_reglist_seq;
    import QuplsPkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        start;
    logic [63:0] mask;
    logic [6:0]  rn0, rn1, rn2, rn3;
    aregno_t     regcnt;
    logic        busy;
    logic        last;

    int n_vec  = 0;
    int n_fail = 0;

    qupls_reglist_seq dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .flush_i  (flush),
        .start_i  (start),
        .mask_i   (mask),
        .iRn0_o   (rn0),
        .iRn1_o   (rn1),
        .iRn2_o   (rn2),
        .iRn3_o   (rn3),
        .regcnt_o (regcnt),
        .busy_o   (busy),
        .last_o   (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_grp(input string tag,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input int e_cnt, input logic e_busy, input logic e_last);
        check_eq({tag, ".rn"}, {rn0, rn1, rn2, rn3}, {e0, e1, e2, e3});
        check_eq({tag, ".regcnt"}, 64'(regcnt), 64'(e_cnt));
        check_eq({tag, ".busy"}, 64'(busy), 64'(e_busy));
        check_eq({tag, ".last"}, 64'(last), 64'(e_last));
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        mask  = '0;
        step();
        check_grp("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic list 0xF6 -> {1,2,4,5} then {6,7}.
        en = 1'b1; start = 1'b1; mask = 64'h00F6;
        step();
        start = 1'b0; mask = '0;
        check_grp("basic.g0", 7'd1, 7'd2, 7'd4, 7'd5, 0, 1'b1, 1'b0);
        step();
        check_grp("basic.g1", 7'd6, 7'd7, 7'h7F, 7'h7F, 4, 1'b0, 1'b1);
        step();
        check_grp("basic.idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);

        // Full mask: 16 groups of consecutive registers.
        start = 1'b1; mask = '1;
        step();
        start = 1'b0; mask = '0;
        for (int g = 0; g < 16; g++) begin
            check_grp($sformatf("full.g%0d", g),
                      7'(4*g), 7'(4*g+1), 7'(4*g+2), 7'(4*g+3),
                      4*g, (g != 15), (g == 15));
            step();
        end
        check_grp("full.idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);

        // Stall: outputs hold while en is low, then group1 follows.
        start = 1'b1; mask = 64'h00F6;
        step();
        start = 1'b0; mask = '0; en = 1'b0;
        check_grp("stall.g0", 7'd1, 7'd2, 7'd4, 7'd5, 0, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step();
            check_grp($sformatf("stall.hold%0d", s), 7'd1, 7'd2, 7'd4, 7'd5, 0, 1'b1, 1'b0);
        end
        en = 1'b1;
        step();
        check_grp("stall.g1", 7'd6, 7'd7, 7'h7F, 7'h7F, 4, 1'b0, 1'b1);

        // Ignored start while busy, then back-to-back start on the final group.
        start = 1'b1; mask = 64'h00F6;
        step();
        check_grp("ign.g0", 7'd1, 7'd2, 7'd4, 7'd5, 0, 1'b1, 1'b0);
        mask = 64'hFF00;
        step();
        check_grp("ign.g1", 7'd6, 7'd7, 7'h7F, 7'h7F, 4, 1'b0, 1'b1);
        mask = 64'h8000_0000_0000_0001;
        step();
        check_grp("b2b.g0", 7'd0, 7'd63, 7'h7F, 7'h7F, 0, 1'b0, 1'b1);
        mask = '0;
        step();
        start = 1'b0;
        check_grp("empty", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);

        // Flush with en low discards the remainder.
        start = 1'b1; mask = 64'hFFFF;
        step();
        start = 1'b0; mask = '0;
        check_grp("flush.g0", 7'd0, 7'd1, 7'd2, 7'd3, 0, 1'b1, 1'b0);
        en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check_grp("flush.after", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_grp("flush.idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);

        // Async reset mid-list, then clean restart.
        start = 1'b1; mask = 64'hFFFF;
        step();
        start = 1'b0; mask = '0;
        step();
        check_grp("rst.g1", 7'd4, 7'd5, 7'd6, 7'd7, 4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_grp("rst.async", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        start = 1'b1; mask = 64'h0030;
        step();
        start = 1'b0; mask = '0;
        check_grp("rst.restart", 7'd4, 7'd5, 7'h7F, 7'h7F, 0, 1'b0, 1'b1);
        step();
        check_grp("rst.idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/qupls_reglist_seq.md
# qupls_reglist_seq

Register bit-list sequencer for load/store-multiple instructions. It sits in the fetch/extract stage and drives the four per-slot register numbers (`iRn0`..`iRn3`) consumed by the instruction-extract stage. Each enabled cycle it takes a latched 64-bit register bitmap and emits the next four lowest set register numbers. It holds fetch (`busy_o`) until the list is exhausted.

## Interface
- No parameters. Types come from QuplsPkg.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `en_i`  in  1  pipeline advance. This is the same enable that drives the extract stage.
- `flush_i`  in  1  synchronous abort of any list in progress.
- `start_i`  in  1  decoder has found a register-list instruction; `mask_i` is valid.
- `mask_i`  in  64  register bitmap. Bit n set means register n is in the list.
- `iRn0_o`..`iRn3_o`  out  7 each  register number for slots 0–3. `7'h7F` means no register.
- `regcnt_o`  out  aregno_t  count of registers emitted before the current group (packing base).
- `busy_o`  out  1  more groups remain after the current one; fetch must hold the PC.
- `last_o`  out  1  the current outputs are the final group of a list.

## Operation
- State: `rem` (64b remaining mask), output registers `iRn0..3`, and `regcnt`.
- Group extraction:
  - Find the lowest set bit of the source mask → slot0. Clear it, take the next lowest → slot1, and so on up to four.
  - Missing slots get `7'h7F`.
  - Register numbers are 6-bit, zero-extended to 7 bits (bit6 = 0). Register 63 = `7'h3F` is valid.
- `busy_o` = (`rem` != 0).
- `last_o` = (`iRn0_o` != `7'h7F`) && (`rem` == 0).
- Priority within a cycle:
  1. `flush_i`: acts regardless of `en_i`. Sets `rem` = 0, all `iRn` = `7'h7F`, `regcnt` = 0.
  2. `en_i` = 0: all registers hold.
  3. `en_i` = 1 and `rem` != 0: the group comes from `rem`. Clear those bits from `rem`. `regcnt` += 4, because the previous group is always full when `rem` != 0. `start_i` is ignored.
  4. `en_i` = 1, `rem` == 0, `start_i` = 1: the group comes from `mask_i`. `rem` = `mask_i` with the group bits cleared. `regcnt` = 0.
  5. `en_i` = 1, `rem` == 0, `start_i` = 0: all `iRn` = `7'h7F`, `regcnt` = 0 (idle).
- `start_i` with `mask_i` = 0 produces an all-`7F` group. `busy_o` and `last_o` stay 0.
- Back-to-back lists are allowed:
  - `start_i` is accepted in the cycle the final group is presented (`rem` == 0).
  - The new list's group0 appears the next cycle with no idle bubble.
- The extract stage treats `iRn0` = `7'h7F` as non-list mode. The sequencer therefore never presents a group with slot0 = `7F` and a later slot valid.

## Timing
- Reset (async, `rst_ni` low):
  - All `iRn*_o` = `7'h7F`.
  - `rem` = 0, so `busy_o` = 0.
  - `regcnt_o` = 0, `last_o` = 0.
- Latency: `start_i` sampled at edge N (with `en_i`) → group0 on the outputs after edge N, valid through cycle N+1.
- Group k of a list with P registers appears k enabled cycles after group0. The list takes ceil(P/4) enabled cycles.
- All outputs are registered, or derived from registered state only. There is no combinational path from the inputs to the outputs.
- Flush and reset mid-list discard the remaining bits. A subsequent `start_i` behaves as if starting fresh.

## Test plan
- Basic list:
  - Stimulus: `mask_i` = `64'h00F6`, `start_i` pulse, `en_i` = 1.
  - Cycle 1: `iRn` = {1,2,4,5}, `regcnt` 0, `busy` 1, `last` 0.
  - Cycle 2: {6,7,7F,7F}, `regcnt` 4, `busy` 0, `last` 1.
  - Cycle 3: all `7F`, `last` 0.
- Full mask:
  - Stimulus: `mask_i` = all ones.
  - 16 groups. Group 15 = {60,61,62,63}, `regcnt` 60, `last` 1.
- Stall:
  - Stimulus: same as the basic list, `en_i` = 0 for 3 cycles after group0.
  - Outputs hold {1,2,4,5}. `rem` is unchanged. Group1 follows the first enabled cycle.
- Back-to-back and empty:
  - Stimulus: second `start_i` with `mask_i` = `64'h8000_0000_0000_0001` during the final group of the first list.
  - Next cycle: {0,63,7F,7F}, `regcnt` 0, `last` 1.
  - Stimulus: `start_i` with `mask_i` = 0 → all `7F`, `busy` 0, `last` 0.
- Flush and reset:
  - Stimulus: `flush_i` asserted after group0 of `mask_i` = `64'hFFFF`, with `en_i` = 0.
  - Next cycle: all `7F`, `busy` 0.
  - Repeat with `rst_ni` pulsed low mid-list → immediate reset values, then a clean restart from a new `start_i`.
- Ignored start:
  - Stimulus: `start_i` while `busy_o` = 1.
  - The current list continues unchanged; the new mask is dropped.
